// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared FSM encoding, error codes and default SOF for the UART frame decoder
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        DATA,
        CHK,
        HOLD
    } state_t;

    localparam logic [1:0] ERR_LENGTH   = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: DEPTH x 8 payload store, one write port and a registered read port
//   clk, rst          : clock, synchronous active-high reset (clears only the read register)
//   we, waddr, wdata  : write port
//   raddr, rdata      : read port, one-cycle latency; out-of-range addresses read 8'h00
module uart_frame_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Storage has no reset so it maps onto block or distributed RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // The range guard only exists when the address can exceed the depth.
    if ((2 ** AW) > DEPTH) begin : g_guard
        always_ff @(posedge clk) begin
            if (rst) rdata <= 8'h00;
            else rdata <= (int'(raddr) >= DEPTH) ? 8'h00 : mem[raddr];
        end
    end else begin : g_plain
        always_ff @(posedge clk) begin
            if (rst) rdata <= 8'h00;
            else rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: assembles SOF/CMD/LEN/payload/XOR-checksum frames from a uart_rx byte stream
//   clk, rst              : clock, synchronous active-high reset
//   rx_data, rx_valid     : incoming byte and its one-cycle strobe
//   frame_valid           : a checksum-good frame is held
//   frame_cmd, frame_len  : CMD byte and payload length of the held frame
//   rd_addr, rd_data      : payload read port, one-cycle latency
//   frame_ack             : consumer releases the held frame
//   frame_err, err_code   : one-cycle error pulse; code 0=LENGTH 1=CHECKSUM 2=TIMEOUT 3=OVERRUN
// Build option UART_FRAME_TIMEOUT_EN adds the mid-frame inter-byte timeout.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 64,
    parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF,
    parameter int         TIMEOUT_CYCLES = 20480,
    localparam int        LEN_W          = $clog2(MAX_LEN + 1),
    localparam int        AW             = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             frame_valid,
    output logic [7:0]       frame_cmd,
    output logic [LEN_W-1:0] frame_len,
    input  logic [AW-1:0]    rd_addr,
    output logic [7:0]       rd_data,
    input  logic             frame_ack,
    output logic             frame_err,
    output logic [1:0]       err_code
);

    state_t           state, state_n;
    logic [7:0]       cmd, chk;
    logic [LEN_W-1:0] len, idx;
    logic             err_set, we, len_bad, last;
    logic [1:0]       code_set;

    assign len_bad     = rx_data > 8'(MAX_LEN);
    assign last        = idx == len - LEN_W'(1);
    assign frame_valid = state == HOLD;
    assign frame_cmd   = cmd;
    assign frame_len   = len;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          active, tmo;
    assign active = state inside {CMD, LEN, DATA, CHK};
    // Fires on the TIMEOUT_CYCLES-th consecutive byte-free cycle mid-frame.
    assign tmo = active && !rx_valid && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst || rx_valid || !active || tmo) tmo_cnt <= '0;
        else tmo_cnt <= tmo_cnt + TW'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n  = state;
        err_set  = 1'b0;
        code_set = err_code;
        we       = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: state_n = rx_data == SOF_BYTE ? CMD : IDLE;
                CMD:  state_n = LEN;
                LEN: begin
                    state_n  = len_bad ? IDLE : rx_data == 8'd0 ? CHK : DATA;
                    err_set  = len_bad;
                    code_set = ERR_LENGTH;
                end
                DATA: begin
                    we      = 1'b1;
                    state_n = last ? CHK : DATA;
                end
                CHK: begin
                    state_n  = rx_data == chk ? HOLD : IDLE;
                    err_set  = rx_data != chk;
                    code_set = ERR_CHECKSUM;
                end
                HOLD: begin
                    err_set  = 1'b1;
                    code_set = ERR_OVERRUN;
                end
                default: state_n = IDLE;
            endcase
        end
        // An ack still releases the frame even when a byte is dropped as overrun.
        if (state == HOLD && frame_ack) state_n = IDLE;
`ifdef UART_FRAME_TIMEOUT_EN
        if (tmo) begin
            state_n  = IDLE;
            err_set  = 1'b1;
            code_set = ERR_TIMEOUT;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            err_code  <= ERR_LENGTH;
            cmd       <= 8'h00;
            len       <= '0;
            idx       <= '0;
            chk       <= 8'h00;
        end else begin
            frame_err <= err_set;
            if (err_set) err_code <= code_set;
            if (rx_valid) begin
                case (state)
                    CMD: begin
                        cmd <= rx_data;
                        chk <= rx_data;
                    end
                    LEN: begin
                        if (!len_bad) begin
                            len <= rx_data[LEN_W-1:0];
                            chk <= chk ^ rx_data;
                            idx <= '0;
                        end
                    end
                    DATA: begin
                        chk <= chk ^ rx_data;
                        idx <= idx + LEN_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (idx[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
